// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// parity-mode constants and serial line levels.
package uart_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ENC_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ENC_START  = 3'd1;
    localparam logic [STATE_W-1:0] ENC_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ENC_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ENC_STOP   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = ENC_IDLE,
        START  = ENC_START,
        DATA   = ENC_DATA,
        PARITY = ENC_PARITY,
        STOP   = ENC_STOP
    } tx_state_t;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the
// last cycle of each bit. clr realigns the count to a new frame.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST_CNT)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_done = (cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one word from the TX FIFO and shifts it out
// as start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int STOP_W = 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);
    localparam logic              PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD
                                                                : PARITY_MODE_EVEN;

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_next;
    logic                  parity_q, parity_next;
    logic [IDX_W-1:0]      bit_idx, bit_idx_next;
    logic [STOP_W-1:0]     stop_cnt, stop_cnt_next;
    logic                  tx_q, tx_next;
    logic                  bit_done;
    logic                  last_stop;
    logic                  load;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (load),
        .bit_done (bit_done)
    );

    // rst_n gates load so no pop strobe can leak out while reset is held.
    always_comb begin
        last_stop = (state == STOP) && bit_done && (stop_cnt == LAST_STOP);
        load      = rst_n && tx_en && !fifo_empty && ((state == IDLE) || last_stop);

        state_next    = state;
        shift_next    = shift_q;
        parity_next   = parity_q;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;

        if (load) begin
            state_next    = START;
            shift_next    = fifo_data;
            parity_next   = (^fifo_data) ^ PAR_MODE;
            bit_idx_next  = '0;
            stop_cnt_next = '0;
        end else begin
            case (state)
                START: begin
                    if (bit_done) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_next = shift_q >> 1;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx_next  = '0;
                            stop_cnt_next = '0;
                            state_next    = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx_next = bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        stop_cnt_next = '0;
                        state_next    = STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (last_stop) begin
                            stop_cnt_next = '0;
                            state_next    = IDLE;
                        end else begin
                            stop_cnt_next = stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // The line level is derived from the next state so tx comes straight off a flop.
    always_comb begin
        case (state_next)
            START:   tx_next = LINE_START;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_idx  <= '0;
            stop_cnt <= '0;
            tx_q     <= LINE_IDLE;
        end else begin
            state    <= state_next;
            bit_idx  <= bit_idx_next;
            stop_cnt <= stop_cnt_next;
            tx_q     <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shift_q  <= shift_next;
        parity_q <= parity_next;
    end

    assign fifo_rd_en = load;
    assign busy       = (state != IDLE) || load;
    assign tx         = tx_q;

endmodule
